// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the MCU multiplexed address/data bus.
// Used by the bus master and by benches that build register-window addresses.
package mcu_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_AHOLD,
    ST_DATA,
    ST_TURN
  } bus_state_e;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  localparam int DEF_ADDSET  = 2;
  localparam int DEF_ADDHLD  = 1;
  localparam int DEF_DATAST  = 4;
  localparam int DEF_BUSTURN = 1;

  // Register window: base field ADDR[18:7], channel ADDR[6:4], register ADDR[3:0].
  localparam logic [11:0] REG_BASE = {4'b1010, 8'h00};

  function automatic logic [ADDR_W-1:0] reg_addr(input logic [2:0] chan, input logic [3:0] regn);
    return {REG_BASE, chan, regn};
  endfunction

  // Phase counter width: clog2 of the longest phase, never below 3 bits.
  function automatic int phase_cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return ($clog2(m) < 3) ? 3 : $clog2(m);
  endfunction

endpackage

// File: rtl/bus_phase_timer.sv
// Loadable down-counter shared by every bus phase; zero marks the last cycle of a phase.
module bus_phase_timer #(
  parameter int W = 3
) (
  input  logic         int_clk,
  input  logic         NRST,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge int_clk) begin
    if (!NRST) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mcu_bus_master.sv
// Initiator for the MCU multiplexed bus: one command becomes address, data and
// turnaround phases. All bus strobes are registered from the next-state decode.
module mcu_bus_master
  import mcu_bus_pkg::*;
#(
  parameter int ADDSET  = DEF_ADDSET,
  parameter int ADDHLD  = DEF_ADDHLD,
  parameter int DATAST  = DEF_DATAST,
  parameter int BUSTURN = DEF_BUSTURN
) (
  input  logic              int_clk,
  input  logic              NRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] AD_OUT,
  output logic              AD_OE,
  input  logic [DATA_W-1:0] AD_IN,
  output logic [2:0]        A_HI,
  output logic              NE,
  output logic              NADV,
  output logic              NOE,
  output logic              NWE
);

  localparam int CNT_W = phase_cnt_width(ADDSET, ADDHLD, DATAST, BUSTURN);
  localparam logic [CNT_W-1:0] ADDSET_LD  = CNT_W'(ADDSET - 1);
  localparam logic [CNT_W-1:0] ADDHLD_LD  = CNT_W'(ADDHLD - 1);
  localparam logic [CNT_W-1:0] DATAST_LD  = CNT_W'(DATAST - 1);
  localparam logic [CNT_W-1:0] BUSTURN_LD = CNT_W'(BUSTURN - 1);

  bus_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ld;
  logic [CNT_W-1:0]  ld_val;
  logic              zero;
  logic              ready_d, rsp_d, capture_rd;
  logic              ne_d, nadv_d, noe_d, nwe_d, oe_d;
  logic [DATA_W-1:0] ad_d;
  logic [2:0]        ahi_d;

  bus_phase_timer #(.W(CNT_W)) u_timer (
    .int_clk  (int_clk),
    .NRST     (NRST),
    .load     (ld),
    .load_val (ld_val),
    .zero     (zero)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ld         = 1'b0;
    ld_val     = '0;
    rsp_d      = 1'b0;
    capture_rd = 1'b0;

    unique case (state_q)
      ST_IDLE: if (cmd_valid && cmd_ready) begin
        write_d = cmd_write;
        addr_d  = cmd_addr;
        wdata_d = cmd_wdata;
        ld      = 1'b1;
        ld_val  = ADDSET_LD;
        state_d = ST_ADDR;
      end
      ST_ADDR: if (zero) begin
        ld      = 1'b1;
        ld_val  = ADDHLD_LD;
        state_d = ST_AHOLD;
      end
      ST_AHOLD: if (zero) begin
        ld      = 1'b1;
        ld_val  = DATAST_LD;
        state_d = ST_DATA;
      end
      ST_DATA: if (zero) begin
        ld         = 1'b1;
        ld_val     = BUSTURN_LD;
        capture_rd = !write_q;
        state_d    = ST_TURN;
      end
      ST_TURN: if (zero) begin
        rsp_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs decoded from the next state so they register cleanly at the edge.
    ready_d = (state_d == ST_IDLE);
    nadv_d  = (state_d != ST_ADDR);
    ne_d    = !((state_d inside {ST_ADDR, ST_AHOLD, ST_DATA}) ||
                (state_d == ST_TURN && state_q == ST_DATA));
    noe_d   = !(state_d == ST_DATA && !write_d);
    nwe_d   = !(state_d == ST_DATA && write_d);
    oe_d    = (state_d inside {ST_ADDR, ST_AHOLD}) || (state_d == ST_DATA && write_d);

    // AD_OUT and A_HI hold by default: write data stays through TURN, address between cycles.
    ad_d  = AD_OUT;
    ahi_d = A_HI;
    if (state_d inside {ST_ADDR, ST_AHOLD}) begin
      ad_d  = addr_d[15:0];
      ahi_d = addr_d[18:16];
    end else if (state_d == ST_DATA && write_d) begin
      ad_d = wdata_d;
    end
  end

  always_ff @(posedge int_clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    if (!NRST) begin
      state_q   <= ST_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      AD_OUT    <= '0;
      AD_OE     <= 1'b0;
      A_HI      <= '0;
      NE        <= 1'b1;
      NADV      <= 1'b1;
      NOE       <= 1'b1;
      NWE       <= 1'b1;
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cmd_ready <= ready_d;
      rsp_valid <= rsp_d;
      if (capture_rd) rsp_rdata <= AD_IN;
      AD_OUT    <= ad_d;
      AD_OE     <= oe_d;
      A_HI      <= ahi_d;
      NE        <= ne_d;
      NADV      <= nadv_d;
      NOE       <= noe_d;
      NWE       <= nwe_d;
    end
  end

endmodule

// File: tb/tb_mcu_bus_master.sv
// Directed and table-driven bench for mcu_bus_master, with responder models for a
// default-timing instance and a minimum-timing instance.
module tb_mcu_bus_master;
  import mcu_bus_pkg::*;

  logic int_clk = 1'b0;
  always #5 int_clk = ~int_clk;

  // Default-timing DUT
  logic        nrst, cmd_valid, cmd_ready, cmd_write, rsp_valid;
  logic [18:0] cmd_addr;
  logic [15:0] cmd_wdata, rsp_rdata, ad_out, ad_in;
  logic        ad_oe, ne, nadv, noe, nwe;
  logic [2:0]  a_hi;

  mcu_bus_master dut (
    .int_clk(int_clk), .NRST(nrst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .AD_OUT(ad_out), .AD_OE(ad_oe),
    .AD_IN(ad_in), .A_HI(a_hi), .NE(ne), .NADV(nadv), .NOE(noe), .NWE(nwe)
  );

  // Minimum-timing DUT
  logic        m_nrst, m_valid, m_ready, m_write, m_rsp_valid;
  logic [18:0] m_addr;
  logic [15:0] m_wdata, m_rdata, m_ad_out, m_ad_in;
  logic        m_ad_oe, m_ne, m_nadv, m_noe, m_nwe;
  logic [2:0]  m_a_hi;

  mcu_bus_master #(.ADDSET(1), .ADDHLD(1), .DATAST(2), .BUSTURN(1)) dut_min (
    .int_clk(int_clk), .NRST(m_nrst), .cmd_valid(m_valid), .cmd_ready(m_ready),
    .cmd_write(m_write), .cmd_addr(m_addr), .cmd_wdata(m_wdata),
    .rsp_valid(m_rsp_valid), .rsp_rdata(m_rdata), .AD_OUT(m_ad_out), .AD_OE(m_ad_oe),
    .AD_IN(m_ad_in), .A_HI(m_a_hi), .NE(m_ne), .NADV(m_nadv), .NOE(m_noe), .NWE(m_nwe)
  );

  // Responder models: latch address on NADV rise, data on NWE rise, drive reads while NOE low.
  logic [18:0] lat_addr, m_lat_addr;
  logic [15:0] lat_data, m_lat_data, rd_val;

  always @(posedge nadv)   lat_addr   <= {a_hi, ad_out};
  always @(posedge nwe)    lat_data   <= ad_out;
  always @(posedge m_nadv) m_lat_addr <= {m_a_hi, m_ad_out};
  always @(posedge m_nwe)  m_lat_data <= m_ad_out;

  assign ad_in   = noe   ? 16'h0000 : rd_val;
  assign m_ad_in = m_noe ? 16'h0000 : (m_lat_addr[15:0] ^ 16'h5A5A);

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle recording of one transaction; cycle 1 is the first cycle after the accept edge.
  logic        rec_nadv [0:31];
  logic        rec_nwe  [0:31];
  logic        rec_noe  [0:31];
  logic        rec_ne   [0:31];
  logic        rec_oe   [0:31];
  logic        rec_rv   [0:31];
  logic        rec_rdy  [0:31];
  logic [15:0] rec_ad   [0:31];
  logic [2:0]  rec_ahi  [0:31];

  task automatic run_txn(input logic w, input logic [18:0] a, input logic [15:0] d,
                         output int lat, output int nrsp);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 40) begin
      @(negedge int_clk);
      guard++;
    end
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    @(posedge int_clk);
    #1;
    cmd_valid = 1'b0; cmd_write = ~w; cmd_addr = 19'h7FFFF; cmd_wdata = 16'hFFFF;
    lat = -1; nrsp = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge int_clk);
      rec_nadv[c] = nadv; rec_nwe[c] = nwe; rec_noe[c] = noe; rec_ne[c] = ne;
      rec_oe[c] = ad_oe; rec_rv[c] = rsp_valid; rec_rdy[c] = cmd_ready;
      rec_ad[c] = ad_out; rec_ahi[c] = a_hi;
      if (rsp_valid) begin
        nrsp++;
        if (lat < 0) lat = c - 1;
      end
      if (lat >= 0 && c >= lat + 3) break;
    end
  endtask

  task automatic run_m(input logic w, input logic [18:0] a, input logic [15:0] d, output int lat);
    int guard;
    guard = 0;
    while (m_ready !== 1'b1 && guard < 20) begin
      @(negedge int_clk);
      guard++;
    end
    m_valid = 1'b1; m_write = w; m_addr = a; m_wdata = d;
    @(posedge int_clk);
    #1;
    m_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge int_clk);
      check("min_noe_nwe_exclusive", 32'(!m_noe && !m_nwe), 0);
      check("min_nadv_vs_strobes", 32'(!m_nadv && (!m_noe || !m_nwe)), 0);
      if (m_rsp_valid) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  typedef struct {
    logic        wr;
    logic [18:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd_val;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:5];

  initial begin
    int          lat, nrsp, busy, first, second, cnt;
    logic        ne_at_first;
    logic [8:0]  mk_nadv, mk_nwe, mk_noe, mk_ne, mk_oe, mk_rv, mk_rdy;
    logic        w;
    logic [18:0] a;
    logic [15:0] d;

    vecs[0] = '{1'b1, reg_addr(3'd1, 4'h0), 16'hA5C3, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, reg_addr(3'd2, 4'h5), 16'h0000, 16'h1234, 16'h1234};
    vecs[2] = '{1'b1, 19'h7FFFF,            16'h0001, 16'h0000, 16'h1234};
    vecs[3] = '{1'b0, 19'h00000,            16'h0000, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{1'b1, reg_addr(3'd7, 4'h0), 16'h8000, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b0, reg_addr(3'd0, 4'hF), 16'h0000, 16'h0F0F, 16'h0F0F};

    nrst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rd_val = '0;
    m_nrst = 1'b0; m_valid = 1'b0; m_write = 1'b0; m_addr = '0; m_wdata = '0;

    // Reset state
    repeat (3) @(posedge int_clk);
    @(negedge int_clk);
    check("reset_flags{rdy,ne,nadv,noe,nwe,oe,rv}",
          {25'd0, cmd_ready, ne, nadv, noe, nwe, ad_oe, rsp_valid}, 32'b0111100);
    check("reset_ad_out", ad_out, 0);
    check("reset_a_hi", a_hi, 0);
    check("reset_rsp_rdata", rsp_rdata, 0);
    @(posedge int_clk);
    #1 nrst = 1'b1; m_nrst = 1'b1;
    @(negedge int_clk);
    check("ready_lags_reset_release", cmd_ready, 0);
    @(negedge int_clk);
    check("ready_after_reset", cmd_ready, 1);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      rd_val = vecs[i].rd_val;
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, nrsp);
      check($sformatf("v%0d_latency", i), lat, 8);
      check($sformatf("v%0d_rsp_count", i), nrsp, 1);
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_latched_addr", i), lat_addr, vecs[i].addr);
      if (vecs[i].wr) check($sformatf("v%0d_latched_data", i), lat_data, vecs[i].wdata);
      for (int c = 1; c <= 9; c++) begin
        mk_nadv[c-1] = rec_nadv[c]; mk_nwe[c-1] = rec_nwe[c]; mk_noe[c-1] = rec_noe[c];
        mk_ne[c-1] = rec_ne[c]; mk_oe[c-1] = rec_oe[c]; mk_rv[c-1] = rec_rv[c];
        mk_rdy[c-1] = rec_rdy[c];
      end
      if (i == 0) begin
        check("wr_nadv_wave", mk_nadv, 9'b111111100);
        check("wr_nwe_wave", mk_nwe, 9'b110000111);
        check("wr_noe_wave", mk_noe, 9'b111111111);
        check("wr_ne_wave", mk_ne, 9'b100000000);
        check("wr_oe_wave", mk_oe, 9'b001111111);
        check("wr_rsp_wave", mk_rv, 9'b100000000);
        check("wr_ready_wave", mk_rdy, 9'b100000000);
        check("wr_ad_c1", rec_ad[1], 16'h0010);
        check("wr_ad_c3", rec_ad[3], 16'h0010);
        check("wr_ahi_c1", rec_ahi[1], 3'b101);
        check("wr_ad_c4", rec_ad[4], 16'hA5C3);
        check("wr_ad_c7", rec_ad[7], 16'hA5C3);
        check("wr_ad_turn", rec_ad[8], 16'hA5C3);
        check("wr_ahi_holds_idle", rec_ahi[9], 3'b101);
      end
      if (i == 1) begin
        check("rd_noe_wave", mk_noe, 9'b110000111);
        check("rd_nwe_wave", mk_nwe, 9'b111111111);
        check("rd_oe_wave", mk_oe, 9'b000000111);
        check("rd_ne_wave", mk_ne, 9'b100000000);
        check("rd_ad_c1", rec_ad[1], 16'h0025);
      end
    end

    // Command pulses while busy must be ignored
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 19'h50030; cmd_wdata = 16'h3C3C;
    @(posedge int_clk);
    #1 cmd_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge int_clk);
      if (rsp_valid) begin
        lat = c - 1;
        break;
      end
      cmd_valid = (c == 2 || c == 6);
      cmd_write = 1'b0;
      cmd_addr  = (c == 2) ? 19'h2ABCD : 19'h1FFFF;
      cmd_wdata = 16'h0BAD;
    end
    cmd_valid = 1'b0;
    check("busy_latency", lat, 8);
    check("busy_latched_addr", lat_addr, 19'h50030);
    check("busy_latched_data", lat_data, 16'h3C3C);
    check("busy_rdata_unchanged", rsp_rdata, 16'h0F0F);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge int_clk);
      if (!ne || !nadv || !noe || !nwe || rsp_valid) cnt++;
    end
    check("busy_no_followup_activity", cnt, 0);

    // Reset in the third DATA cycle of a write
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 19'h50040; cmd_wdata = 16'h7777;
    @(posedge int_clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge int_clk);
    #1 nrst = 1'b0;
    @(negedge int_clk);
    check("rst_pre_nwe_low", nwe, 0);
    @(posedge int_clk);
    #1;
    check("rst_nwe", nwe, 1);
    check("rst_ne", ne, 1);
    check("rst_ad_oe", ad_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rdata_cleared", rsp_rdata, 0);
    check("rst_ready_low", cmd_ready, 0);
    @(posedge int_clk);
    #1 nrst = 1'b1;
    @(negedge int_clk);
    check("rst_ready_still_low", cmd_ready, 0);
    @(negedge int_clk);
    check("rst_ready_one_cycle_after", cmd_ready, 1);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge int_clk);
      if (rsp_valid) cnt++;
    end
    check("rst_no_rsp", cnt, 0);

    // Back-to-back with cmd_valid held high
    rd_val = 16'hBEEF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 19'h50050; cmd_wdata = 16'h1111;
    @(posedge int_clk);
    #1 cmd_write = 1'b0; cmd_addr = 19'h50061; cmd_wdata = 16'h0000;
    busy = 0; nrsp = 0; first = 0; second = 0; ne_at_first = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge int_clk);
      if (!cmd_ready) busy++;
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 1) begin
          first = c;
          ne_at_first = ne;
          @(posedge int_clk);
          #1 cmd_valid = 1'b0;
        end else begin
          second = c;
          break;
        end
      end
    end
    cmd_valid = 1'b0;
    check("b2b_first_rsp_cycle", first, 9);
    check("b2b_second_rsp_cycle", second, 18);
    check("b2b_busy_cycles", busy, 16);
    check("b2b_ne_gap", ne_at_first, 1);
    check("b2b_write_data", lat_data, 16'h1111);
    check("b2b_read_addr", lat_addr, 19'h50061);
    check("b2b_read_data", rsp_rdata, 16'hBEEF);

    // Minimum timing: directed read, then random traffic with strobe checks
    @(negedge int_clk);
    run_m(1'b0, 19'h50025, 16'h0000, lat);
    check("min_read_latency", lat, 5);
    check("min_read_data", m_rdata, 16'h5A7F);
    for (int t = 0; t < 1000; t++) begin
      w = 1'($urandom_range(0, 1));
      a = 19'($urandom);
      d = 16'($urandom);
      run_m(w, a, d, lat);
      check("min_rand_latency", lat, 5);
      check("min_rand_addr", m_lat_addr, a);
      if (w) check("min_rand_wdata", m_lat_data, d);
      else   check("min_rand_rdata", m_rdata, a[15:0] ^ 16'h5A5A);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
